// File: rtl/xbox_port_arbiter.sv
// Round-robin arbiter sharing the single XBOX row port between NREQ requesters, with
// registered XBOX commands and in-order read-return routing. Optional burst lock: XBOX_ARB_LOCK_EN.
//
// state | meaning
// RUN   | granting requests round-robin from the rr pointer
// DRAIN | quiesce requested: no grants, waiting for command/tag pipe to empty
// QUIET | port drained, held off until quiesce drops
module xbox_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 14,
    parameter int DW     = 1024,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
`ifdef XBOX_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    input  logic               quiesce,
    output logic               idle,
    output logic               xbox_rd,
    output logic               xbox_wr,
    output logic [AW-1:0]      xbox_addr,
    output logic [DW-1:0]      xbox_wdata,
    input  logic [DW-1:0]      xbox_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_en;
    logic            gnt_found;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   ptr_next;
    logic [IW-1:0]   cmd_id;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            busy;
    logic [RD_LAT-1:0] tag_v;
    logic [IW-1:0]   tag_id [RD_LAT];

    // Search from the rr pointer upward with wrap; first valid requester wins.
    always_comb begin : grant
        int idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        idx       = 0;
        if (grant_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!gnt_found && req_valid[idx]) begin
                    gnt_found = 1'b1;
                    gnt_id    = IW'(idx);
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IW'(1);
`ifdef XBOX_ARB_LOCK_EN
        // A locked burst keeps the pointer on its owner so the next search lands on it again.
        if (req_lock[gnt_id]) begin
            ptr_next = gnt_id;
        end
`endif
    end

    assign sel_we    = req_we[gnt_id];
    assign sel_addr  = req_addr[int'(gnt_id)*AW +: AW];
    assign sel_wdata = req_wdata[int'(gnt_id)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xbox_rd    <= 1'b0;
            xbox_wr    <= 1'b0;
            xbox_addr  <= '0;
            xbox_wdata <= '0;
            cmd_id     <= '0;
            rr_ptr     <= '0;
        end else begin
            xbox_rd <= gnt_found & ~sel_we;
            xbox_wr <= gnt_found & sel_we;
            if (gnt_found) begin
                xbox_addr <= sel_addr;
                cmd_id    <= gnt_id;
                rr_ptr    <= ptr_next;
                if (sel_we) begin
                    xbox_wdata <= sel_wdata;
                end
            end
        end
    end

    // Stage 0 loads the cycle after xbox_rd, so the last stage lines up with xbox_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= xbox_rd;
            tag_id[0] <= cmd_id;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (tag_v[RD_LAT-1]) begin
            rsp_valid[tag_id[RD_LAT-1]] = 1'b1;
            rsp_rdata                   = xbox_rdata;
        end
    end

    assign busy = (|tag_v) | xbox_rd | xbox_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        idle     = 1'b0;
        case (state_q)
            RUN: begin
                grant_en = ~quiesce;
                idle     = ~(|req_valid) & ~busy;
                if (quiesce) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!quiesce) begin
                    state_d = RUN;
                end else if (!busy) begin
                    state_d = QUIET;
                end
            end
            QUIET: begin
                idle = 1'b1;
                if (!quiesce) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_xbox_port_arbiter.sv
// Directed, table-driven bench for xbox_port_arbiter with a behavioural XBOX row memory
// and a read-return scoreboard. Lock sequence is compiled only with XBOX_ARB_LOCK_EN.
module tb_xbox_port_arbiter;

    localparam int NREQ   = 2;
    localparam int AW     = 14;
    localparam int DW     = 1024;
    localparam int RD_LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
`ifdef XBOX_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               quiesce;
    logic               idle;
    logic               xbox_rd;
    logic               xbox_wr;
    logic [AW-1:0]      xbox_addr;
    logic [DW-1:0]      xbox_wdata;
    logic [DW-1:0]      xbox_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xbox_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef XBOX_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .quiesce    (quiesce),
        .idle       (idle),
        .xbox_rd    (xbox_rd),
        .xbox_wr    (xbox_wr),
        .xbox_addr  (xbox_addr),
        .xbox_wdata (xbox_wdata),
        .xbox_rdata (xbox_rdata)
    );

    function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int w = 0; w < DW/32; w++) r[w*32 +: 32] = {a, 2'b00, 16'(w)} ^ 32'h5A5A_0000;
        return r;
    endfunction

    task automatic chk_bit(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_bit(name, act === exp, act, exp);
    endtask

    // Behavioural XBOX: read data appears RD_LAT cycles after xbox_rd, writes land at the edge.
    logic [DW-1:0] xmem [64];
    logic [63:0]   xmem_w;
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (!rst_n) xmem_w <= '0;
        else if (xbox_wr) begin
            xmem[xbox_addr[5:0]]   <= xbox_wdata;
            xmem_w[xbox_addr[5:0]] <= 1'b1;
        end
        rd_pipe[0] <= xmem_w[xbox_addr[5:0]] ? xmem[xbox_addr[5:0]] : row_of(xbox_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign xbox_rdata = rd_pipe[RD_LAT-1];

    typedef struct {
        int            id;
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          expq[$];
    logic [DW-1:0] rmem [64];
    logic [63:0]   rmem_w;

    always @(negedge clk) begin : mon
        logic [AW-1:0] a;
        exp_t          e;
        if (!rst_n) begin
            expq.delete();
            rmem_w = '0;
        end else begin
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            chk("rd_wr_exclusive", 64'(xbox_rd & xbox_wr), 64'd0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    a = req_addr[i*AW +: AW];
                    if (req_we[i]) begin
                        rmem[a[5:0]]   = req_wdata[i*DW +: DW];
                        rmem_w[a[5:0]] = 1'b1;
                    end else begin
                        e.id   = i;
                        e.due  = cyc + RD_LAT + 1;
                        e.data = rmem_w[a[5:0]] ? rmem[a[5:0]] : row_of(a);
                        expq.push_back(e);
                    end
                end
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(1 << expq[0].id));
                chk_bit("rsp_rdata", rsp_rdata === expq[0].data, rsp_rdata[63:0], expq[0].data[63:0]);
                void'(expq.pop_front());
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
        end
    end

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic        q;
        logic [1:0]  ready;
        logic        rd;
        logic        wr;
        logic [13:0] addr;
        logic        idle;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic seen;
        req_valid = '0;
        req_we    = '0;
        quiesce   = 1'b0;
        req_addr  = {14'h0020, 14'h0010};
        req_wdata = {{32{32'hFFFF_0000}}, {32{32'h1234_ABCD}}};
`ifdef XBOX_ARB_LOCK_EN
        req_lock  = '0;
`endif
        //           v      we     q     ready  rd    wr    addr     idle
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0000, 1'b1});
        tbl.push_back('{2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 14'h0000, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b1});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b1});
        tbl.push_back('{2'b01, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b1});
        tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b1});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0010, 1'b1});
        tbl.push_back('{2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 14'h0010, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0020, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 14'h0020, 1'b1});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state held with no requests.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_state",
                64'({req_ready, rsp_valid, xbox_rd, xbox_wr, xbox_addr, idle, |rsp_rdata, |xbox_wdata}),
                64'({2'b00, 2'b00, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b0, 1'b0}));
        end

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            req_valid = tbl[i].v;
            req_we    = tbl[i].we;
            quiesce   = tbl[i].q;
            @(negedge clk);
            chk($sformatf("vec[%0d]", i),
                64'({req_ready, xbox_rd, xbox_wr, xbox_addr, idle}),
                64'({tbl[i].ready, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].idle}));
        end

        // Quiesce with two reads in flight.
        req_addr = {14'h0200, 14'h0100};
        @(posedge clk); #1 req_valid = 2'b11; req_we = 2'b00; quiesce = 1'b0;
        @(negedge clk); chk("drain_grant0", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        @(negedge clk); chk("drain_grant1", 64'(req_ready), 64'b10);
        @(posedge clk); #1 quiesce = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 0) bad++;
            if (idle) break;
        end
        chk("quiesce_no_grant", 64'(bad), 64'd0);
        chk("quiesce_idle", 64'(idle), 64'd1);
        chk("quiesce_drained", 64'(expq.size()), 64'd0);
        @(posedge clk); #1 quiesce = 1'b0;
        @(negedge clk); chk("resume_quiet_cycle", 64'(req_ready), 64'b00);
        @(posedge clk); #1;
        @(negedge clk); chk("resume_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (5) @(posedge clk);

        // Requester 1 writes all-ones to the top row, then reads it back.
        #1;
        req_addr[AW +: AW]  = 14'h3FFF;
        req_wdata[DW +: DW] = '1;
        req_valid = 2'b10;
        req_we    = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = req_ready[1];
            if (!seen) begin @(posedge clk); #1; end
        end
        chk("wr_accept", 64'(seen), 64'd1);
        @(posedge clk); #1 req_we = 2'b00;
        @(negedge clk);
        chk("wr_cmd", 64'({xbox_wr, xbox_rd, xbox_addr}), 64'({1'b1, 1'b0, 14'h3FFF}));
        chk_bit("wr_data", xbox_wdata === {DW{1'b1}}, xbox_wdata[63:0], {64{1'b1}});
        chk("rd_accept", 64'(req_ready), 64'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk("rd_cmd", 64'({xbox_wr, xbox_rd, xbox_addr}), 64'({1'b0, 1'b1, 14'h3FFF}));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid[1];
        end
        chk("rd_rsp_seen", 64'(seen), 64'd1);
        chk_bit("rd_rsp_ones", rsp_rdata === {DW{1'b1}}, rsp_rdata[63:0], {64{1'b1}});
        repeat (4) @(posedge clk);

        // Reset asserted with reads in flight: no stale return afterwards.
        #1 req_valid = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1 req_valid = 2'b00; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
        end

`ifdef XBOX_ARB_LOCK_EN
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 2'b11;
            req_lock  = (k < 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk($sformatf("lock_grant[%0d]", k), 64'(req_ready), 64'b01);
        end
        @(posedge clk); #1 req_lock = 2'b00;
        @(negedge clk); chk("lock_release", 64'(req_ready), 64'b10);
`else
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk); chk("ptr_after_reset", 64'(req_ready), 64'b01);
`endif
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
